counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 104 ++++++++++
 tb/tb_counter_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that runs one job at a time through a shared load/expire counter.
// Optional WAIT watchdog with err pulse is enabled by defining COUNTER_ARB_TIMEOUT_EN.
module counter_arbiter #(
    parameter int DW = 6,
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_din,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [DW-1:0]      cnt_din,
    output logic               cnt_ena,
    input  logic               cnt_oflag,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
    state_t state;
    logic [1:0] ptr, sel;
    logic found;
    logic [DW-1:0] slice;
    // search starts one past the last grant, so the last winner comes last
    always_comb begin
        sel = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                sel = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end
    assign slice = req_din[sel*DW +: DW];
`ifdef COUNTER_ARB_TIMEOUT_EN
    logic [6:0] wd;
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            done <= '0;
            busy <= 1'b0;
            cnt_ena <= 1'b0;
            cnt_din <= '0;
            ptr <= 2'd3;
`ifdef COUNTER_ARB_TIMEOUT_EN
            wd <= '0;
            err <= 1'b0;
`endif
        end else begin
            done <= '0;
            cnt_ena <= 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: if (found) begin
                    gnt <= '0;
                    gnt[sel] <= 1'b1;
                    cnt_din <= slice;
                    ptr <= sel;
                    busy <= 1'b1;
                    if (slice == '0) begin
                        state <= DONE;
                        done[sel] <= 1'b1;
                    end else begin
                        state <= LOAD;
                        cnt_ena <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT;
`ifdef COUNTER_ARB_TIMEOUT_EN
                    wd <= '0;
`endif
                end
                WAIT: begin
                    if (cnt_oflag) begin
                        state <= DONE;
                        done <= gnt;
                    end
`ifdef COUNTER_ARB_TIMEOUT_EN
                    else if (wd == 7'd126) begin
                        state <= DONE;
                        done <= gnt;
                        err <= 1'b1;
                    end else begin
                        wd <= wd + 7'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    gnt <= '0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed vector table, reset/hang sequences and a timestamp-based random model.
module tb_counter_arbiter;
    logic clk = 1'b0, rst = 1'b1, cnt_oflag = 1'b0;
    logic [3:0] req = '0;
    logic [23:0] req_din = '0;
    logic [3:0] gnt, done;
    logic busy, cnt_ena, err;
    logic [5:0] cnt_din;
    int tests = 0, fails = 0, cyc = 0;

    counter_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_din(req_din), .gnt(gnt), .done(done),
        .busy(busy), .cnt_din(cnt_din), .cnt_ena(cnt_ena), .cnt_oflag(cnt_oflag), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [23:0] din;
        logic [3:0] eg;
        logic [5:0] ev;
        int d;
        logic drop;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // one complete job; the counter expiry is returned d cycles after the load strobe
    task automatic job(input vec_t v);
        req = v.r;
        req_din = v.din;
        tick();
        chk("grant", gnt, v.eg);
        if (v.drop) req = '0;
        if (v.ev == 0) begin
            chk("zero_done", {done, cnt_ena, busy}, {v.eg, 2'b01});
        end else begin
            chk("load", {cnt_ena, cnt_din, busy, done}, {1'b1, v.ev, 1'b1, 4'h0});
            for (int i = 1; i <= v.d; i++) begin
                tick();
                chk("wait", {cnt_ena, busy, done, gnt}, {2'b01, 4'h0, v.eg});
            end
            cnt_oflag = 1'b1;
            tick();
            cnt_oflag = 1'b0;
            chk("done", {done, gnt, busy}, {v.eg, v.eg, 1'b1});
        end
        tick();
        chk("idle", {gnt, done, busy, cnt_ena}, 32'h0);
    endtask

    int gs, ge, ena, ofc, win, last;
    logic [5:0] val, pval;
    logic inj, got;
    logic [3:0] eg;

    initial begin
        tbl[0]  = '{4'b0001, 24'h000008, 4'b0001, 6'd8,  8, 1'b0};
        tbl[1]  = '{4'b1111, 24'h17F042, 4'b0010, 6'd1,  1, 1'b0};
        tbl[2]  = '{4'b1111, 24'h17F042, 4'b0100, 6'd63, 3, 1'b0};
        tbl[3]  = '{4'b1111, 24'h17F042, 4'b1000, 6'd5,  2, 1'b0};
        tbl[4]  = '{4'b1111, 24'h17F042, 4'b0001, 6'd2,  1, 1'b0};
        tbl[5]  = '{4'b0100, 24'h140042, 4'b0100, 6'd0,  0, 1'b0};
        tbl[6]  = '{4'b1010, 24'h17F042, 4'b1000, 6'd5,  4, 1'b0};
        tbl[7]  = '{4'b1010, 24'h17F042, 4'b0010, 6'd1,  2, 1'b0};
        tbl[8]  = '{4'b0011, 24'h17F000, 4'b0001, 6'd0,  0, 1'b0};
        tbl[9]  = '{4'b0011, 24'h17F000, 4'b0010, 6'd0,  0, 1'b0};
        tbl[10] = '{4'b1000, 24'h17F042, 4'b1000, 6'd5,  5, 1'b1};
        tbl[11] = '{4'b1000, 24'h17F042, 4'b1000, 6'd5,  1, 1'b0};
        tick();
        tick();
        chk("reset", {gnt, done, busy, cnt_ena, cnt_din, err}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) job(tbl[i]);
        // reset while waiting on the counter drops the job and rewinds the pointer
        req = 4'b0010;
        req_din = 24'h17F042;
        tick();
        chk("rst_grant", gnt, 4'b0010);
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_wait", {gnt, done, busy, cnt_ena, cnt_din, err}, 32'h0);
        rst = 1'b0;
        cnt_oflag = 1'b1;
        tick();
        cnt_oflag = 1'b0;
        chk("rst_no_done", {gnt, done, busy}, 32'h0);
        tick();
        chk("rst_no_done2", {gnt, done, busy}, 32'h0);
        job('{4'b1111, 24'h17F042, 4'b0001, 6'd2, 2, 1'b0});
        job('{4'b0010, 24'h17F042, 4'b0010, 6'd1, 1, 1'b0});
        // counter expiry withheld
        req = 4'b0100;
        tick();
        chk("hang_grant", {gnt, cnt_ena}, {4'b0100, 1'b1});
        req = '0;
`ifdef COUNTER_ARB_TIMEOUT_EN
        for (int i = 1; i <= 127; i++) begin
            tick();
            chk("wd_wait", {busy, err, done}, {2'b10, 4'h0});
        end
        tick();
        chk("timeout", {err, done, busy}, {1'b1, 4'b0100, 1'b1});
`else
        for (int i = 1; i <= 200; i++) begin
            tick();
            chk("hang_busy", {busy, err, done}, {2'b10, 4'h0});
        end
        cnt_oflag = 1'b1;
        tick();
        cnt_oflag = 1'b0;
        chk("hang_done", {done, err}, {4'b0100, 1'b0});
`endif
        tick();
        chk("hang_idle", {gnt, busy, err}, 32'h0);
        // random phase: jobs tracked as grant/load/done timestamps
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gs = cyc;
        ge = cyc - 1;
        ena = -1;
        ofc = -1;
        win = 0;
        last = 3;
        val = '0;
        pval = '0;
        for (int n = 0; n < 400; n++) begin
            inj = (cyc >= gs) && (cyc <= ge);
            eg = inj ? 4'(1 << win) : 4'h0;
            chk("random", {gnt, done, busy, cnt_ena, cnt_din, err},
                {eg, (cyc == ge) ? eg : 4'h0, inj, cyc == ena, (cyc >= gs) ? val : pval, 1'b0});
            req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            for (int s = 0; s < 4; s++) req_din[s*6 +: 6] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            cnt_oflag = (cyc == ofc) || ((cyc <= ena || cyc > ofc) && $urandom_range(0, 4) == 0);
            if (cyc > ge && req != 0) begin
                got = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!got && req[(last + k) % 4]) begin
                        win = (last + k) % 4;
                        got = 1'b1;
                    end
                end
                pval = val;
                val = req_din[win*6 +: 6];
                gs = cyc + 1;
                last = win;
                if (val == 0) begin
                    ge = cyc + 1;
                    ena = -1;
                    ofc = -1;
                end else begin
                    ena = cyc + 1;
                    ofc = ena + int'($urandom_range(1, 6));
                    ge = ofc + 1;
                end
            end
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
